// File: rtl/ffe_coeff_bank.sv
// rtl/ffe_coeff_bank.sv - Live FFE tap bank gating CMA updates by warm-up, decimation, freeze and software load
module ffe_coeff_bank #(
   parameter int FFE_LEN       = 21,
   parameter int NB            = 8,
   parameter int NBF           = 7,
   parameter int CENTER_INIT   = 64,
   parameter int STARTUP_DELAY = 63,
   parameter int UPDATE_PERIOD = 1,
   parameter int NB_CNT        = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_valid,
   input  logic [FFE_LEN*NB-1:0] i_new_coeff,
   input  logic                  i_freeze,
   input  logic                  i_restart,
   input  logic                  i_load,
   input  logic [FFE_LEN*NB-1:0] i_load_coeff,
   output logic [FFE_LEN*NB-1:0] o_coeff_flat,
   output logic                  o_update_en,
   output logic [1:0]            o_state,
   output logic [NB_CNT-1:0]     o_update_count
);

   localparam int W          = FFE_LEN * NB;
   localparam int CENTER_TAP = (FFE_LEN - 1) / 2;

   // Centre-tap spike used after reset and restart.
   localparam logic [W-1:0] SPIKE_TAPS =
      {{(W - NB){1'b0}}, NB'(CENTER_INIT)} << (CENTER_TAP * NB);

   // Terminal counts: warm-up ends and a commit fires when the counter sits on these.
   localparam logic [NB_CNT-1:0] WARM_LAST = NB_CNT'(STARTUP_DELAY - 1);
   localparam logic [NB_CNT-1:0] DEC_LAST  = NB_CNT'(UPDATE_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_ADAPT  = 2'd2,
      ST_FROZEN = 2'd3
   } state_t;

   state_t            state;
   logic [NB_CNT-1:0] warm_cnt;
   logic [NB_CNT-1:0] dec_cnt;

   // Zero-length warm-up or decimation would make the terminal counts meaningless.
   if (STARTUP_DELAY < 1 || UPDATE_PERIOD < 1 || NBF >= NB) begin : g_bad_params
      $error("ffe_coeff_bank: STARTUP_DELAY/UPDATE_PERIOD must be >= 1 and NBF < NB");
   end

   assign o_state = state;

   // Tap bank, gating FSM and counters; restart beats load beats freeze beats the CMA commit.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state          <= ST_INIT;
         o_coeff_flat   <= SPIKE_TAPS;
         o_update_en    <= 1'b0;
         o_update_count <= '0;
         warm_cnt       <= '0;
         dec_cnt        <= '0;
      end else begin
         o_update_en <= 1'b0;
         if (i_restart) begin
            state          <= ST_WARMUP;
            o_coeff_flat   <= SPIKE_TAPS;
            o_update_count <= '0;
            warm_cnt       <= '0;
            dec_cnt        <= '0;
         end else if (i_load) begin
            // Software write wins over any coincident CMA update; state and counters hold.
            o_coeff_flat <= i_load_coeff;
         end else begin
            case (state)
               ST_INIT: begin
                  state <= ST_WARMUP;
               end
               ST_WARMUP: begin
                  if (i_valid) begin
                     if (warm_cnt == WARM_LAST) begin
                        state   <= ST_ADAPT;
                        dec_cnt <= '0;
                     end else begin
                        warm_cnt <= warm_cnt + NB_CNT'(1);
                     end
                  end
               end
               ST_ADAPT: begin
                  if (i_freeze) begin
                     // An update landing on the freeze cycle is dropped.
                     state <= ST_FROZEN;
                  end else if (i_valid) begin
                     if (dec_cnt == DEC_LAST) begin
                        o_coeff_flat <= i_new_coeff;
                        dec_cnt      <= '0;
                        o_update_en  <= 1'b1;
                        if (o_update_count != '1) begin
                           o_update_count <= o_update_count + NB_CNT'(1);
                        end
                     end else begin
                        dec_cnt <= dec_cnt + NB_CNT'(1);
                     end
                  end
               end
               ST_FROZEN: begin
                  // Resume with a full decimation period before the next commit.
                  if (!i_freeze) begin
                     state   <= ST_ADAPT;
                     dec_cnt <= '0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ffe_coeff_bank.sv
// tb/tb_ffe_coeff_bank.sv - Randomised self-checking bench for ffe_coeff_bank against a tap-bank reference model
module tb_ffe_coeff_bank;

   localparam int FFE_LEN = 21;
   localparam int NB      = 8;
   localparam int W       = FFE_LEN * NB;
   localparam int NBC1    = 4;

   logic clk = 1'b0;
   logic rst;
   logic valid, freeze, restart, load;
   logic [W-1:0] new_coeff, load_coeff;
   logic [W-1:0] coeff0, coeff1;
   logic upd0, upd1;
   logic [1:0] st0, st1;
   logic [15:0] cnt0;
   logic [NBC1-1:0] cnt1;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one entry per DUT (0 = defaults, 1 = short warm-up, period 4, 4-bit count).
   int sd_of[2]   = '{63, 5};
   int per_of[2]  = '{1, 4};
   int cmax_of[2] = '{65535, 15};
   int m_phase[2];
   int m_warm[2];
   int m_adapt[2];
   int m_count[2];
   bit m_upd[2];
   logic [W-1:0] m_taps[2];

   always #5 clk = ~clk;

   ffe_coeff_bank u_dut0 (
      .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_new_coeff(new_coeff),
      .i_freeze(freeze), .i_restart(restart), .i_load(load), .i_load_coeff(load_coeff),
      .o_coeff_flat(coeff0), .o_update_en(upd0), .o_state(st0), .o_update_count(cnt0)
   );

   ffe_coeff_bank #(.STARTUP_DELAY(5), .UPDATE_PERIOD(4), .NB_CNT(NBC1)) u_dut1 (
      .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_new_coeff(new_coeff),
      .i_freeze(freeze), .i_restart(restart), .i_load(load), .i_load_coeff(load_coeff),
      .o_coeff_flat(coeff1), .o_update_en(upd1), .o_state(st1), .o_update_count(cnt1)
   );

   function automatic logic [W-1:0] fill_taps(input logic [NB-1:0] b);
      logic [W-1:0] v;
      for (int k = 0; k < FFE_LEN; k++) v[k*NB +: NB] = b;
      return v;
   endfunction

   function automatic logic [W-1:0] spike_taps();
      logic [W-1:0] v;
      v = '0;
      v[10*NB +: NB] = 8'h40;
      return v;
   endfunction

   function automatic logic [W-1:0] rand_taps();
      logic [W-1:0] v;
      for (int k = 0; k < FFE_LEN; k++) v[k*NB +: NB] = NB'($urandom);
      return v;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = 0;
         m_warm[d]  = 0;
         m_adapt[d] = 0;
         m_count[d] = 0;
         m_upd[d]   = 1'b0;
         m_taps[d]  = spike_taps();
      end
   endtask

   // Counts valid samples since warm-up / since the last commit and applies the priority rules.
   task automatic model_step(input int d);
      m_upd[d] = 1'b0;
      if (restart) begin
         m_taps[d]  = spike_taps();
         m_warm[d]  = 0;
         m_adapt[d] = 0;
         m_count[d] = 0;
         m_phase[d] = 1;
      end else if (load) begin
         m_taps[d] = load_coeff;
      end else begin
         case (m_phase[d])
            0: m_phase[d] = 1;
            1: begin
               if (valid) begin
                  m_warm[d]++;
                  if (m_warm[d] == sd_of[d]) begin
                     m_phase[d] = 2;
                     m_adapt[d] = 0;
                  end
               end
            end
            2: begin
               if (freeze) begin
                  m_phase[d] = 3;
               end else if (valid) begin
                  m_adapt[d]++;
                  if (m_adapt[d] == per_of[d]) begin
                     m_taps[d]  = new_coeff;
                     m_adapt[d] = 0;
                     m_upd[d]   = 1'b1;
                     if (m_count[d] < cmax_of[d]) m_count[d]++;
                  end
               end
            end
            default: begin
               if (!freeze) begin
                  m_phase[d] = 2;
                  m_adapt[d] = 0;
               end
            end
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int d = 0; d < 2; d++) model_step(d);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b0; freeze = 1'b0; restart = 1'b0; load = 1'b0;
      new_coeff = '0; load_coeff = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      n_checks++; if (coeff0 !== spike_taps()) begin n_fail++; $display("FAIL reset_taps0: got %h want %h", coeff0, spike_taps()); end
      n_checks++; if (st0 !== 2'd0) begin n_fail++; $display("FAIL reset_state0: got %0d want 0", st0); end
      n_checks++; if (upd0 !== 1'b0 || cnt0 !== 16'd0) begin n_fail++; $display("FAIL reset_upd_cnt0: got %b/%0d want 0/0", upd0, cnt0); end
      n_checks++; if (coeff1 !== spike_taps() || st1 !== 2'd0 || cnt1 !== 4'd0) begin n_fail++; $display("FAIL reset_dut1: got %h/%0d/%0d", coeff1, st1, cnt1); end
      rst = 1'b0;
      tick();
      n_checks++; if (st0 !== 2'd1 || st1 !== 2'd1) begin n_fail++; $display("FAIL init_to_warmup: got %0d/%0d want 1/1", st0, st1); end
   endtask

   task automatic test_first_commit();
      bit early;
      bit bad1;
      early = 1'b0; bad1 = 1'b0;
      valid = 1'b1; new_coeff = fill_taps(8'h11);
      for (int i = 0; i < 63; i++) begin
         tick();
         if (coeff0 !== spike_taps() || upd0 !== 1'b0) early = 1'b1;
         if (coeff1 !== m_taps[1] || upd1 !== m_upd[1] || cnt1 !== m_count[1]) bad1 = 1'b1;
      end
      n_checks++; if (early) begin n_fail++; $display("FAIL warmup_hold: taps changed before sample 63, now %h", coeff0); end
      n_checks++; if (bad1) begin n_fail++; $display("FAIL warmup_dut1: got %h/%0d want %h/%0d", coeff1, cnt1, m_taps[1], m_count[1]); end
      n_checks++; if (st0 !== 2'd2) begin n_fail++; $display("FAIL warmup_to_adapt: got %0d want 2", st0); end
      tick();
      n_checks++; if (coeff0 !== fill_taps(8'h11)) begin n_fail++; $display("FAIL first_commit_taps: got %h want all 11", coeff0); end
      n_checks++; if (upd0 !== 1'b1 || cnt0 !== 16'd1) begin n_fail++; $display("FAIL first_commit_flags: got %b/%0d want 1/1", upd0, cnt0); end
      valid = 1'b0;
      tick();
      n_checks++; if (upd0 !== 1'b0 || cnt0 !== 16'd1 || coeff0 !== fill_taps(8'h11)) begin n_fail++; $display("FAIL valid_low_hold: got %b/%0d want 0/1", upd0, cnt0); end
   endtask

   task automatic test_freeze();
      bit moved;
      logic [W-1:0] nc;
      moved = 1'b0;
      valid = 1'b1; freeze = 1'b1;
      for (int i = 0; i < 10; i++) begin
         new_coeff = rand_taps();
         tick();
         if (coeff0 !== fill_taps(8'h11) || st0 !== 2'd3 || upd0 !== 1'b0) moved = 1'b1;
      end
      n_checks++; if (moved) begin n_fail++; $display("FAIL freeze_hold: got %h state %0d", coeff0, st0); end
      n_checks++; if (coeff1 !== m_taps[1] || st1 !== m_phase[1][1:0]) begin n_fail++; $display("FAIL freeze_dut1: got %0d want %0d", st1, m_phase[1]); end
      freeze = 1'b0; new_coeff = rand_taps();
      tick();
      n_checks++; if (st0 !== 2'd2 || coeff0 !== m_taps[0] || upd0 !== m_upd[0]) begin n_fail++; $display("FAIL freeze_release: got %0d/%b want 2/%b", st0, upd0, m_upd[0]); end
      nc = rand_taps(); new_coeff = nc;
      tick();
      n_checks++; if (coeff0 !== nc || upd0 !== 1'b1) begin n_fail++; $display("FAIL post_freeze_commit: got %h/%b want %h/1", coeff0, upd0, nc); end
   endtask

   task automatic test_load();
      int cb;
      logic [W-1:0] lc;
      cb = m_count[0];
      valid = 1'b1; new_coeff = fill_taps(8'h11); load = 1'b1; load_coeff = fill_taps(8'h7F);
      tick();
      n_checks++; if (coeff0 !== fill_taps(8'h7F)) begin n_fail++; $display("FAIL load_wins_taps: got %h want all 7f", coeff0); end
      n_checks++; if (upd0 !== 1'b0 || cnt0 !== 16'(cb)) begin n_fail++; $display("FAIL load_wins_flags: got %b/%0d want 0/%0d", upd0, cnt0, cb); end
      load = 1'b0; new_coeff = fill_taps(8'h22);
      tick();
      n_checks++; if (coeff0 !== fill_taps(8'h22) || cnt0 !== 16'(cb + 1)) begin n_fail++; $display("FAIL after_load_commit: got %h/%0d", coeff0, cnt0); end
      freeze = 1'b1;
      tick();
      lc = rand_taps(); load = 1'b1; load_coeff = lc;
      tick();
      n_checks++; if (coeff0 !== lc || st0 !== 2'd3) begin n_fail++; $display("FAIL load_in_frozen: got %h/%0d want %h/3", coeff0, st0, lc); end
      n_checks++; if (coeff1 !== m_taps[1] || st1 !== m_phase[1][1:0]) begin n_fail++; $display("FAIL load_dut1: got %h/%0d", coeff1, st1); end
      load = 1'b0; freeze = 1'b0;
      tick();
   endtask

   task automatic test_restart_after_100();
      bit early;
      restart = 1'b1; valid = 1'b0;
      tick();
      restart = 1'b0; valid = 1'b1;
      for (int i = 0; i < 163; i++) begin
         new_coeff = rand_taps();
         tick();
      end
      n_checks++; if (cnt0 !== 16'd100 || st0 !== 2'd2) begin n_fail++; $display("FAIL count_100: got %0d/%0d want 100/2", cnt0, st0); end
      n_checks++; if (cnt1 !== 4'hF) begin n_fail++; $display("FAIL count_saturate: got %0d want 15", cnt1); end
      n_checks++; if (coeff1 !== m_taps[1]) begin n_fail++; $display("FAIL sat_taps1: got %h want %h", coeff1, m_taps[1]); end
      restart = 1'b1; new_coeff = rand_taps();
      tick();
      restart = 1'b0;
      n_checks++; if (coeff0 !== spike_taps() || cnt0 !== 16'd0 || st0 !== 2'd1 || upd0 !== 1'b0) begin n_fail++; $display("FAIL restart: got %h/%0d/%0d", coeff0, cnt0, st0); end
      early = 1'b0;
      for (int i = 0; i < 63; i++) begin
         new_coeff = rand_taps();
         tick();
         if (coeff0 !== spike_taps() || upd0 !== 1'b0) early = 1'b1;
      end
      n_checks++; if (early) begin n_fail++; $display("FAIL restart_warmup: commit before 63 samples, taps %h", coeff0); end
      tick();
      n_checks++; if (coeff0 !== m_taps[0] || upd0 !== 1'b1 || cnt0 !== 16'd1) begin n_fail++; $display("FAIL restart_first_commit: got %b/%0d want 1/1", upd0, cnt0); end
   endtask

   task automatic test_period4();
      int pulses;
      bit badt;
      restart = 1'b1; valid = 1'b0;
      tick();
      restart = 1'b0; valid = 1'b1;
      repeat (5) tick();
      n_checks++; if (st1 !== 2'd2 || cnt1 !== 4'd0) begin n_fail++; $display("FAIL p4_enter_adapt: got %0d/%0d want 2/0", st1, cnt1); end
      pulses = 0; badt = 1'b0;
      for (int i = 0; i < 40; i++) begin
         valid = (i % 2 == 0);
         new_coeff = rand_taps();
         tick();
         if (upd1) pulses++;
         if (coeff1 !== m_taps[1]) badt = 1'b1;
      end
      n_checks++; if (pulses != 5 || cnt1 !== 4'd5) begin n_fail++; $display("FAIL p4_commits: got %0d pulses count %0d want 5/5", pulses, cnt1); end
      n_checks++; if (badt) begin n_fail++; $display("FAIL p4_taps: got %h want %h", coeff1, m_taps[1]); end
      n_checks++; if (coeff0 !== m_taps[0] || st0 !== m_phase[0][1:0]) begin n_fail++; $display("FAIL p4_dut0: got %0d want %0d", st0, m_phase[0]); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         valid      = ($urandom_range(0, 3) != 0);
         new_coeff  = rand_taps();
         load_coeff = rand_taps();
         if ($urandom_range(0, 19) == 0) freeze = ~freeze;
         restart = ($urandom_range(0, 99) == 0);
         load    = ($urandom_range(0, 29) == 0);
         tick();
         n_checks++; if (coeff0 !== m_taps[0]) begin n_fail++; $display("FAIL rand_taps0 cyc %0d: got %h want %h", i, coeff0, m_taps[0]); end
         n_checks++; if ({st0, upd0, cnt0} !== {m_phase[0][1:0], m_upd[0], m_count[0][15:0]}) begin n_fail++; $display("FAIL rand_ctl0 cyc %0d: got %0d/%b/%0d want %0d/%b/%0d", i, st0, upd0, cnt0, m_phase[0], m_upd[0], m_count[0]); end
         n_checks++; if (coeff1 !== m_taps[1]) begin n_fail++; $display("FAIL rand_taps1 cyc %0d: got %h want %h", i, coeff1, m_taps[1]); end
         n_checks++; if ({st1, upd1, cnt1} !== {m_phase[1][1:0], m_upd[1], m_count[1][NBC1-1:0]}) begin n_fail++; $display("FAIL rand_ctl1 cyc %0d: got %0d/%b/%0d want %0d/%b/%0d", i, st1, upd1, cnt1, m_phase[1], m_upd[1], m_count[1]); end
      end
   endtask

   task automatic test_async_reset();
      freeze = 1'b0; restart = 1'b0; load = 1'b0; valid = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (coeff0 !== spike_taps() || st0 !== 2'd0 || upd0 !== 1'b0 || cnt0 !== 16'd0) begin n_fail++; $display("FAIL async_reset0: got %h/%0d/%b/%0d", coeff0, st0, upd0, cnt0); end
      n_checks++; if (coeff1 !== spike_taps() || st1 !== 2'd0 || upd1 !== 1'b0 || cnt1 !== 4'd0) begin n_fail++; $display("FAIL async_reset1: got %h/%0d/%b/%0d", coeff1, st1, upd1, cnt1); end
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
      tick();
      n_checks++; if (st0 !== 2'd1 || st1 !== 2'd1) begin n_fail++; $display("FAIL reset_release: got %0d/%0d want 1/1", st0, st1); end
   endtask

   initial begin
      test_reset();
      test_first_commit();
      test_freeze();
      test_load();
      test_restart_after_100();
      test_period4();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
